ug_arbiter: RTL
===============

UG_ARBITER -- requirements
Module: ug_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters; only NREQ=4 is supported.
REQ-002 Parameter W, default 4, operand and result width in bits.
REQ-003 The block SHALL have one clock and one reset: reset is asynchronous and active-high; clk and rst are listed first.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 req  input  4  request per requester i, held high until granted.
REQ-007 req_op  input  12  3-bit opcode per requester; requester i uses bits [3i+2:3i].
REQ-008 req_a  input  16  W-bit operand A per requester; requester i uses bits [4i+3:4i].
REQ-009 req_b  input  16  W-bit operand B per requester, same packing as req_a.
REQ-010 gnt  output  4  one-hot grant, a one-cycle pulse.
REQ-011 rsp_valid  output  1  result valid, a one-cycle pulse.
REQ-012 rsp_id  output  2  index of the requester owning the result.
REQ-013 rsp_y  output  4  result.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 ops_done  output  8  count of completed operations, wrapping.

Function
REQ-016 The block SHALL share one NAND-only bitwise logic unit among 4 requesters; every function SHALL be built solely from 2-input NAND of the latched operands.
REQ-017 Opcode encoding SHALL be:
- 000 NAND
- 001 AND
- 010 OR
- 011 NOT A
- 100 NOR
- 101 XOR
- 110 XNOR
- 111 BUF A
REQ-018 The FSM SHALL have exactly three states, IDLE, EXEC and RESP.
- IDLE -> EXEC when any req bit is high at the clock edge.
- EXEC -> RESP unconditionally.
- RESP -> IDLE unconditionally.
REQ-019 On the IDLE->EXEC edge, the block SHALL:
- select the winner by round-robin from the priority pointer;
- register gnt one-hot for the winner;
- latch the winner's op, a and b, and latch its index into rsp_id.
REQ-020 gnt SHALL be high only during the EXEC cycle and zero in all other states.
REQ-021 On the EXEC->RESP edge, the block SHALL register the logic-unit output into rsp_y.
REQ-022 rsp_valid SHALL be high exactly during the RESP cycle.
REQ-023 rsp_y and rsp_id SHALL hold their values until the next RESP.
REQ-024 Latency SHALL be gnt one cycle after the req sampling edge, and rsp_valid two cycles after it.
REQ-025 Throughput SHALL be at most one operation per 3 cycles.
REQ-026 Round-robin: the pointer resets to 0; the search order is ptr, ptr+1, ... mod 4; after granting i, the pointer becomes (i+1) mod 4 on the RESP->IDLE edge.
REQ-027 Requester protocol: req_op, req_a and req_b SHALL be stable while req is high and ungranted. A requester that still holds req in the cycle after gnt is treated as a new request at the next IDLE.
REQ-028 req changes during EXEC and RESP SHALL be ignored; there is no preemption.
REQ-029 rsp has no backpressure; the consumer SHALL sample it in the RESP cycle.
REQ-030 ops_done SHALL increment by 1 on each RESP->IDLE edge and wrap from 255 to 0.
REQ-031 Simultaneous requests: all four requests high continuously SHALL be granted in order 0, 1, 2, 3, 0, ...

Reset
REQ-032 While rst is high, the block SHALL hold: state=IDLE, ptr=0, gnt=0, rsp_valid=0, rsp_id=0, rsp_y=0, busy=0, ops_done=0.
REQ-033 rst asserted in EXEC or RESP SHALL abort the operation with no rsp_valid pulse and no ops_done increment.
REQ-034 The first arbitration after reset release SHALL occur at the first clock edge with rst low.

Verification
REQ-035 Scenario single: req=0001, op0=000, a0=1100, b0=1010 -> gnt=0001 in cycle +1; rsp_valid=1, rsp_id=0, rsp_y=0111 in cycle +2; ops_done=1.
REQ-036 Scenario all opcodes: a=1100, b=1010 -> results by opcode:
- NAND 0111
- AND 1000
- OR 1110
- NOT 0011
- NOR 0001
- XOR 0110
- XNOR 1001
- BUF 1100
REQ-037 Scenario fairness: req=1111 held for 12 operations -> gnt sequence 0001, 0010, 0100, 1000 repeated 3 times; rsp_id matches each grant.
REQ-038 Scenario pointer: grant to 2, then req=0101 -> next grant=0001, because the search starts at 3 and wraps to 0.
REQ-039 Scenario reset mid-op: rst pulsed during EXEC -> no rsp_valid; gnt=0, ptr=0 and ops_done=0 after release.
REQ-040 Scenario wrap: 256 completed operations -> ops_done=0; the 257th operation -> ops_done=1.

Source files
------------

// File: rtl/ug_arbiter.sv
// ug_arbiter: four requesters share one NAND-built bitwise logic unit.
// A round-robin arbiter grants one requester per three-cycle
// IDLE -> EXEC -> RESP sequence.
module ug_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [3*NREQ-1:0] req_op,
   input  logic [W*NREQ-1:0] req_a,
   input  logic [W*NREQ-1:0] req_b,
   output logic [NREQ-1:0]   gnt,
   output logic              rsp_valid,
   output logic [1:0]        rsp_id,
   output logic [W-1:0]      rsp_y,
   output logic              busy,
   output logic [7:0]        ops_done
);

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   state_t         state;
   state_t         state_nxt;
   logic [1:0]     ptr;
   logic [1:0]     win;
   logic           any_req;
   logic [2:0]     op_p0;
   logic [W-1:0]   a_p0;
   logic [W-1:0]   b_p0;
   logic [W-1:0]   lu_y;

   function automatic logic [W-1:0] nand2(input logic [W-1:0] x, input logic [W-1:0] y);
      return ~(x & y);
   endfunction

   // Every function is a NAND network; the opcode only picks which node drives the result.
   function automatic logic [W-1:0] logic_unit(input logic [2:0] op,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
      logic [W-1:0] n_ab, n_a, n_b, f_and, f_or, f_nor, f_xor, f_xnor, f_buf;
      n_ab   = nand2(a, b);
      n_a    = nand2(a, a);
      n_b    = nand2(b, b);
      f_and  = nand2(n_ab, n_ab);
      f_or   = nand2(n_a, n_b);
      f_nor  = nand2(f_or, f_or);
      f_xor  = nand2(nand2(a, n_ab), nand2(b, n_ab));
      f_xnor = nand2(f_xor, f_xor);
      f_buf  = nand2(n_a, n_a);
      case (op)
         3'b000:  return n_ab;
         3'b001:  return f_and;
         3'b010:  return f_or;
         3'b011:  return n_a;
         3'b100:  return f_nor;
         3'b101:  return f_xor;
         3'b110:  return f_xnor;
         default: return f_buf;
      endcase
   endfunction

   // Round-robin search starting at ptr, wrapping modulo 4.
   always_comb begin
      win     = ptr;
      any_req = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!any_req && req[ptr + 2'(k)]) begin
            win     = ptr + 2'(k);
            any_req = 1'b1;
         end
      end
   end

   assign lu_y = logic_unit(op_p0, a_p0, b_p0);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic: a request starts the fixed three-cycle sequence.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = any_req ? EXEC : IDLE;
         EXEC:    state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Status outputs decoded from the state.
   always_comb begin
      busy      = (state != IDLE);
      rsp_valid = (state == RESP);
   end

   // Control registers: grant pulse, owner id, result, pointer and completion count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt      <= '0;
         rsp_id   <= '0;
         rsp_y    <= '0;
         ptr      <= '0;
         ops_done <= '0;
      end else begin
         gnt <= '0;
         if (state == IDLE && any_req) begin
            gnt[win] <= 1'b1;
            rsp_id   <= win;
         end
         if (state == EXEC) rsp_y <= lu_y;
         if (state == RESP) begin
            ptr      <= rsp_id + 2'd1;
            ops_done <= ops_done + 8'd1;
         end
      end
   end

   // Operand capture for the winner; pure data, so no reset.
   always_ff @(posedge clk) begin
      if (state == IDLE && any_req) begin
         op_p0 <= req_op[win*3 +: 3];
         a_p0  <= req_a[win*W +: W];
         b_p0  <= req_b[win*W +: W];
      end
   end

endmodule
